// File: rtl/button_debouncer.sv
// Button conditioner: two-flop synchronizer, per-bit stability counter, and debounced level with press/release strobes.
// Optional long-press strobe is enabled by defining BUTTON_DEBOUNCER_LONG_PRESS_EN.
module button_debouncer #(
  parameter int unsigned W               = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned LONG_CYCLES     = 50000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_n,
  output logic [W-1:0] pressed,
  output logic [W-1:0] press_pulse,
  output logic [W-1:0] release_pulse,
  output logic [W-1:0] long_pulse
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [W-1:0]  sync1;
  logic [W-1:0]  sync2;
  logic [CW-1:0] cnt     [W];
  logic [CW-1:0] cnt_nxt [W];
  logic [W-1:0]  differ;
  logic [W-1:0]  accept;

  // pressed holds the inverted stable level, so sync differs from stable when sync == pressed
  always_comb begin
    differ = '0;
    accept = '0;
    for (int i = 0; i < W; i++) begin
      cnt_nxt[i] = '0;
      differ[i]  = (sync2[i] == pressed[i]);
      accept[i]  = differ[i] && (cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
      if (differ[i] && !accept[i]) begin
        cnt_nxt[i] = cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1         <= '1;
      sync2         <= '1;
      pressed       <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      for (int i = 0; i < W; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1         <= in_n;
      sync2         <= sync1;
      pressed       <= pressed ^ accept;
      press_pulse   <= accept & ~pressed;
      release_pulse <= accept & pressed;
      for (int i = 0; i < W; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
  localparam int unsigned LW = $clog2(LONG_CYCLES + 1);

  logic [LW-1:0] hold     [W];
  logic [LW-1:0] hold_nxt [W];
  logic [W-1:0]  long_hit;

  // Hold counter saturates at LONG_CYCLES so the strobe fires once per press
  always_comb begin
    long_hit = '0;
    for (int i = 0; i < W; i++) begin
      hold_nxt[i] = '0;
      long_hit[i] = pressed[i] && (hold[i] == LW'(LONG_CYCLES - 1));
      if (pressed[i]) begin
        hold_nxt[i] = (hold[i] == LW'(LONG_CYCLES)) ? hold[i] : hold[i] + LW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      long_pulse <= '0;
      for (int i = 0; i < W; i++) begin
        hold[i] <= '0;
      end
    end else begin
      long_pulse <= long_hit;
      for (int i = 0; i < W; i++) begin
        hold[i] <= hold_nxt[i];
      end
    end
  end
`else
  // Feature disabled: strobe is constant zero for any legal LONG_CYCLES
  assign long_pulse = (LONG_CYCLES == 0) ? {W{1'b1}} : {W{1'b0}};
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer (W=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=20).
module tb_button_debouncer;

  localparam int unsigned W = 2;
  localparam int unsigned D = 4;
  localparam int unsigned L = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_n = '1;
  logic [W-1:0] pressed, press_pulse, release_pulse, long_pulse;

  int n_vec  = 0;
  int n_miss = 0;

  button_debouncer #(.W(W), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .clk(clk), .rst(rst), .in_n(in_n),
    .pressed(pressed), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .long_pulse(long_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [1:0] in_n;
    logic [1:0] pressed;
    logic [1:0] pp;
    logic [1:0] rp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int n, input logic r, input logic [1:0] i,
                              input logic [1:0] p, input logic [1:0] pp, input logic [1:0] rp);
    vec_t v;
    v.rst = r; v.in_n = i; v.pressed = p; v.pp = pp; v.rp = rp;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compares {pressed, press_pulse, release_pulse, long_pulse}
  task automatic check(input string name, input logic [7:0] exp);
    logic [7:0] act;
    act = {pressed, press_pulse, release_pulse, long_pulse};
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got p=%b pp=%b rp=%b lp=%b, want p=%b pp=%b rp=%b lp=%b",
               name, act[7:6], act[5:4], act[3:2], act[1:0],
               exp[7:6], exp[5:4], exp[3:2], exp[1:0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  initial begin
    int pp_cyc;
    int long_cyc;
    int n_long;

    // reset with both input levels, then settle released
    add(1, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00);
    add(1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    add(4, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00);
    // clean press on bit 0: accepted on edge 6
    add(5, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00);
    add(1, 1'b0, 2'b10, 2'b01, 2'b01, 2'b00);
    add(2, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00);
    // release bit 0 while pressing bit 1
    add(5, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00);
    add(1, 1'b0, 2'b01, 2'b10, 2'b10, 2'b01);
    add(1, 1'b0, 2'b01, 2'b10, 2'b00, 2'b00);
    // release bit 1
    add(5, 1'b0, 2'b11, 2'b10, 2'b00, 2'b00);
    add(1, 1'b0, 2'b11, 2'b00, 2'b00, 2'b10);
    add(1, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00);
    // bounce on bit 0 never reaches the count
    for (int r = 0; r < 2; r++) begin
      add(2, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00);
      add(2, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00);
    end
    add(6, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00);

    for (int k = 0; k < vecs.size(); k++) begin
      rst  = vecs[k].rst;
      in_n = vecs[k].in_n;
      step();
      check($sformatf("vec%0d", k), {vecs[k].pressed, vecs[k].pp, vecs[k].rp, 2'b00});
    end

    // press bit 1, then async reset mid-cycle while held
    in_n = 2'b01;
    repeat (5) step();
    check("mid_pre_edge5", 8'b00_00_00_00);
    step();
    check("mid_press", 8'b10_10_00_00);
    step();
    step();
    check("mid_held", 8'b10_00_00_00);
    #2 rst = 1'b1;
    #1 check("async_rst", 8'b00_00_00_00);
    step();
    step();
    check("rst_held", 8'b00_00_00_00);
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step();
      check($sformatf("post_rst_e%0d", e), 8'b00_00_00_00);
    end
    step();
    check("post_rst_press", 8'b10_10_00_00);
    step();
    check("post_rst_hold", 8'b10_00_00_00);

    // release everything before the long-press sequence
    in_n = 2'b11;
    repeat (8) step();
    check("idle", 8'b00_00_00_00);

    // long press on bit 0
    pp_cyc = -1; long_cyc = -1; n_long = 0;
    in_n = 2'b10;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (press_pulse[0]) pp_cyc = c;
      if (long_pulse[0]) begin
        n_long++;
        long_cyc = c;
      end
      if (long_pulse[1]) n_long += 100;
    end
    check_int("long_press_cycle", pp_cyc, 6);
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    check_int("long_count", n_long, 1);
    check_int("long_delay", long_cyc - pp_cyc, int'(L));
`else
    check_int("long_count", n_long, 0);
`endif
    in_n = 2'b11;
    repeat (7) step();
    check("final_idle", 8'b00_00_00_00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
